// File: rtl/pattern_101_gen.sv
// Serial "101" pattern generator: builds a 16-bit word holding N non-overlapping
// "101" occurrences, shifts it out MSB-first over valid/ready, and recounts the stream.
module pattern_101_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  count,
    input  logic        ser_ready,
    output logic        ser_out,
    output logic        ser_valid,
    output logic [15:0] word_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  chk_cnt,
    output logic        chk_fail
);
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned MAX_CNT = 5;

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {C_S0, C_S1, C_S10} chk_state_t;

    state_t             state, state_d;
    chk_state_t         cst, cst_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [CNT_W-1:0]   cnt_lat, cnt_lat_d;
    logic [WORD_W-1:0]  word_d;
    logic [CNT_W-1:0]   chk_cnt_d;
    logic               ser_out_d, ser_valid_d, busy_d, done_d, err_d, chk_fail_d;

    // Occurrence i occupies bits [15-3i : 13-3i] as 3'b101.
    function automatic logic [WORD_W-1:0] build_word(input logic [CNT_W-1:0] n);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(MAX_CNT); i++) begin
            if (CNT_W'(i) < n) begin
                w[15 - 3*i] = 1'b1;
                w[13 - 3*i] = 1'b1;
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cst       <= C_S0;
            idx       <= '0;
            cnt_lat   <= '0;
            word_out  <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            chk_cnt   <= '0;
            chk_fail  <= 1'b0;
        end else begin
            state     <= state_d;
            cst       <= cst_d;
            idx       <= idx_d;
            cnt_lat   <= cnt_lat_d;
            word_out  <= word_d;
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            chk_cnt   <= chk_cnt_d;
            chk_fail  <= chk_fail_d;
        end
    end

    always_comb begin
        state_d     = state;
        cst_d       = cst;
        idx_d       = idx;
        cnt_lat_d   = cnt_lat;
        word_d      = word_out;
        ser_out_d   = ser_out;
        ser_valid_d = ser_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        chk_cnt_d   = chk_cnt;
        chk_fail_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count <= IDX_W'(MAX_CNT)) begin
                        cnt_lat_d   = count[CNT_W-1:0];
                        word_d      = build_word(count[CNT_W-1:0]);
                        idx_d       = IDX_W'(WORD_W - 1);
                        ser_out_d   = word_d[WORD_W-1];
                        ser_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        chk_cnt_d   = '0;
                        cst_d       = C_S0;
                        state_d     = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    // Non-overlapping checker: a completed "101" restarts from scratch.
                    unique case (cst)
                        C_S0:  if (ser_out) cst_d = C_S1;
                        C_S1:  if (!ser_out) cst_d = C_S10;
                        C_S10: begin
                            cst_d = C_S0;
                            if (ser_out && chk_cnt != 3'd7) chk_cnt_d = chk_cnt + 3'd1;
                        end
                        default: cst_d = C_S0;
                    endcase

                    if (idx == '0) begin
                        state_d     = IDLE;
                        ser_valid_d = 1'b0;
                        ser_out_d   = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        chk_fail_d  = (chk_cnt_d != cnt_lat);
                    end else begin
                        idx_d     = idx - IDX_W'(1);
                        ser_out_d = word_out[idx_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pattern_101_gen.sv
// Directed bench for pattern_101_gen: frame contents, handshake stalls, err, ignored start, reset abort.
module tb_pattern_101_gen;
    logic        clk = 1'b0;
    logic        rst_n, start, ser_ready;
    logic [3:0]  count;
    logic        ser_out, ser_valid, busy, done, err, chk_fail;
    logic [15:0] word_out;
    logic [2:0]  chk_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_words [0:5] = '{16'h0000, 16'hA000, 16'hB400, 16'hB680, 16'hB6D0, 16'hB6DA};

    pattern_101_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .ser_ready(ser_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .word_out(word_out), .busy(busy),
        .done(done), .err(err), .chk_cnt(chk_cnt), .chk_fail(chk_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Greedy MSB-first non-overlapping "101" counter.
    function automatic int model101(input logic [15:0] w);
        int st = 0;
        int c  = 0;
        for (int i = 15; i >= 0; i--) begin
            case (st)
                0: if (w[i]) st = 1;
                1: if (!w[i]) st = 2;
                default: begin
                    if (w[i]) c++;
                    st = 0;
                end
            endcase
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_frame(input int n, input bit rnd, input bit mid);
        logic [15:0] rx;
        logic        held;
        bit          stalled;
        int          got, cyc;
        start = 1'b1;
        count = 4'(n);
        ser_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("busy_start_n%0d", n), 32'(busy), 32'(1));
        check($sformatf("word_n%0d", n), 32'(word_out), 32'(exp_words[n]));
        check($sformatf("model_n%0d", n), 32'(model101(word_out)), 32'(n));
        rx = '0; held = 1'b0; stalled = 0; got = 0; cyc = 0;
        while (got < 16 && cyc < 400) begin
            if (!ser_valid || done) begin
                check($sformatf("valid_in_frame_n%0d", n), {30'd0, ser_valid, done}, 32'h2);
                break;
            end
            if (stalled) check($sformatf("stall_hold_n%0d", n), 32'(ser_out), 32'(held));
            if (mid && got == 5) begin
                start = 1'b1;
                count = 4'd2;
            end else begin
                start = 1'b0;
            end
            ser_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ser_ready) begin
                rx = {rx[14:0], ser_out};
                got++;
                stalled = 0;
            end else begin
                held = ser_out;
                stalled = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ser_ready = 1'b1;
        check($sformatf("transfers_n%0d", n), 32'(got), 32'(16));
        check($sformatf("bits_n%0d", n), 32'(rx), 32'(exp_words[n]));
        check($sformatf("done_n%0d", n), 32'(done), 32'(1));
        check($sformatf("idle_flags_n%0d", n), {29'd0, busy, ser_valid, err}, 32'h0);
        check($sformatf("chk_cnt_n%0d", n), 32'(chk_cnt), 32'(n));
        check($sformatf("chk_fail_n%0d", n), 32'(chk_fail), 32'(0));
        if (mid) check("mid_start_word", 32'(word_out), 32'(exp_words[n]));
    endtask

    task automatic err_probe(input logic [3:0] n, input logic [15:0] prev);
        start = 1'b1;
        count = n;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("err_pulse_c%0d", n), 32'(err), 32'(1));
        check($sformatf("err_busy_c%0d", n), 32'(busy), 32'(0));
        check($sformatf("err_word_c%0d", n), 32'(word_out), 32'(prev));
        @(negedge clk);
        check($sformatf("err_clear_c%0d", n), 32'(err), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; count = 4'd0; ser_ready = 1'b1;
        #1;
        check("reset_flags", {25'd0, ser_out, ser_valid, busy, done, err, chk_fail, 1'b0}, 32'h0);
        check("reset_word", 32'(word_out), 32'h0);
        check("reset_chk_cnt", 32'(chk_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(5, 0, 0);
        for (int n = 0; n < 5; n++) run_frame(n, 0, 0);
        run_frame(5, 1, 0);
        @(negedge clk);
        check("chk_cnt_hold", 32'(chk_cnt), 32'(5));

        err_probe(4'd6, 16'hB6DA);
        err_probe(4'd15, 16'hB6DA);

        run_frame(3, 0, 1);
        @(negedge clk);

        // Abort a count=3 frame while bit index 8 is on the wire.
        start = 1'b1; count = 4'd3; ser_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("idx8_bit", 32'(ser_out), 32'(0));
        check("idx8_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_flags", {26'd0, ser_out, ser_valid, busy, done, err, chk_fail}, 32'h0);
        check("abort_word", 32'(word_out), 32'h0);
        check("abort_chk_cnt", 32'(chk_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_done", 32'(done), 32'(0));
        run_frame(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_101_gen.md
# pattern_101_gen

Serial pattern generator that is the transmit-side counterpart of the team's non-overlapping "101" counter. On a start request it builds a 16-bit word containing exactly the requested number of non-overlapping "101" occurrences, as scored by that counter's MSB-first greedy rule. It then shifts the word out MSB-first over a valid/ready serial interface. An internal serial checker recounts the emitted stream so the bench and system can confirm that generator and counter agree.

## Interface
- No parameters: word width is fixed at 16, pattern fixed at 3'b101, maximum count fixed at 5.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- count  input  4  requested occurrences, legal range 0..5
- ser_ready  input  1  downstream accepts the current bit
- ser_out  output  1  current serial bit, MSB first
- ser_valid  output  1  ser_out is valid
- word_out  output  16  word being transmitted, held until next accepted start
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse after the last bit is accepted
- err  output  1  one-cycle pulse when start arrives with count > 5
- chk_cnt  output  3  non-overlap "101" count recomputed from emitted bits
- chk_fail  output  1  with done: chk_cnt != latched count

## Operation
- States: IDLE, SHIFT.
- IDLE + start + count<=5:
  - latch count;
  - load word_out;
  - bit index = 15;
  - clear checker;
  - go to SHIFT.
- IDLE + start + count>5: pulse err, stay IDLE, word_out unchanged.
- Word construction for N = count: occurrence i (0..N-1) places 3'b101 at bits [15-3i : 13-3i]; all other bits 0.
  - Required words: N=0 0x0000, N=1 0xA000, N=2 0xB400, N=3 0xB680, N=4 0xB6D0, N=5 0xB6DA.
- SHIFT:
  - ser_valid=1 and ser_out=word_out[index].
  - A transfer is a cycle with ser_valid & ser_ready; it decrements the index.
  - No transfer: index and ser_out hold.
- Transfer at index 0: go to IDLE, pulse done (and chk_fail if mismatch) in the following cycle.
- start during SHIFT is ignored (no err, no reload).
- Checker follows the counter's rule. It runs a serial non-overlap FSM on transferred bits:
  - states S0 (none), S1 ("1"), S10 ("10");
  - a 1 in S10 increments chk_cnt and returns to S0 (no overlap);
  - S0: 1 goes to S1, 0 stays in S0;
  - S1: 0 goes to S10, 1 stays in S1;
  - S10: 0 goes to S0.
- chk_cnt saturates at 7 and holds its value after done until the next accepted start.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE;
  - ser_out, ser_valid, busy, done, err, chk_fail = 0;
  - word_out = 0x0000, chk_cnt = 0.
- Reset mid-SHIFT aborts immediately: no done, no partial-state retention.
- Accepted start at edge k: busy and ser_valid high from k to k+16 with ser_ready tied 1; first bit visible after k.
- With ser_ready=1 continuously:
  - 16 transfers occupy cycles k+1..k+16;
  - done pulses for the single cycle after the edge that accepts bit 0;
  - busy and ser_valid drop in that same cycle.
- A new start is accepted in the done cycle (state is IDLE); back-to-back frames therefore have one idle cycle between them.
- All outputs are registered; no combinational path from inputs to outputs.
- err is high for exactly the cycle after the offending start edge.

## Test plan
- count=5, ser_ready=1: word_out=0xB6DA; bits 1011011011011010 on 16 consecutive cycles; done one cycle later; chk_cnt=5; chk_fail=0.
- count=0..4 in sequence: words 0x0000/0xA000/0xB400/0xB680/0xB6D0; chk_cnt equals count each frame; start issued in done cycle is accepted.
- count=5 with ser_ready toggled pseudo-randomly: same 16-bit serial sequence, ser_out stable while ser_ready=0, done only after the 16th transfer.
- count=6 and count=15: err pulses one cycle, busy stays 0, word_out keeps the previous value; start mid-SHIFT with count=2: ignored, frame completes unchanged.
- rst_n low at bit index 8 of a count=3 frame: all outputs zero asynchronously; after release, a count=1 frame produces 0xA000 with chk_cnt=1.
- Cross-check: feed each word_out into the 16-bit non-overlap counter model; result equals count for all N=0..5.
